zynq_axi4_mem_responder: RTL and testbench



---
 rtl/zynq_axi4_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_zynq_axi4_mem_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zynq_axi4_mem_responder.sv
// ---------------------------------------------------------------------------
// zynq_axi4_mem_responder
//
// AXI4 (full) slave memory responder. It terminates the 64-bit AXI4 master
// port of the Zynq top level during cosimulation and standalone bring-up,
// standing in for the PS HP/DRAM path. INCR and FIXED bursts are accepted
// on independent read and write paths, with one outstanding burst per
// direction. They are backed by a byte-writable array of MEM_ELS 64-bit
// words.
//
// Ports
//   aclk, aresetn        sole clock, synchronous active-low reset
//   s_axi_aw*            write address channel (addr/id/len/size/burst)
//   s_axi_w*             write data channel (data/strb/last)
//   s_axi_b*             write response channel (id/resp)
//   s_axi_ar*            read address channel (addr/id/len/size/burst)
//   s_axi_r*             read data channel (data/id/resp/last)
//   lock/cache/prot/qos  accepted and ignored, as is s_axi_wid
//   dbg_w_state          current write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//   dbg_r_state          current read FSM state (R_IDLE=0, R_FETCH=1, R_DATA=2)
//
// Handshake semantics (all five channels): a transfer happens on the rising
// edge of aclk where both valid and ready are high. Once this block raises
// a valid (bvalid, rvalid), it holds that valid and every payload signal of
// the channel stable until the transfer happens. The ready outputs here
// (awready, arready, wready) do not depend on the matching valid.
//
// Error handling: a burst with size != 8 bytes or a burst type other than
// FIXED/INCR is still consumed beat for beat. Writes are suppressed and read
// data is forced to zero, and the response carries SLVERR. A W beat whose
// wlast disagrees with the beat count also turns the burst into SLVERR. The
// beat count, not wlast, decides when the burst ends.
//
// Addressing: the low 3 address bits are ignored. Bits above the array index
// are also ignored, so the array aliases through the whole address space.
// INCR bursts wrap from word MEM_ELS-1 to word 0.
// ---------------------------------------------------------------------------
module zynq_axi4_mem_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 6,
  parameter int MEM_ELS            = 1024
) (
  input  logic                            aclk,
  input  logic                            aresetn,

  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awlock,
  input  logic [3:0]                      s_axi_awcache,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awqos,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,

  // write data channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_wid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,

  // write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,

  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arlock,
  input  logic [3:0]                      s_axi_arcache,
  input  logic [2:0]                      s_axi_arprot,
  input  logic [3:0]                      s_axi_arqos,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,

  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,

  // FSM state observation
  output logic [1:0]                      dbg_w_state,
  output logic [1:0]                      dbg_r_state
);

  localparam int IDX_W  = $clog2(MEM_ELS);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A burst is unsupported unless it moves full 8-byte beats and its type
  // is FIXED (00) or INCR (01).
  function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3) || burst[1];
  endfunction

  // -------------------------------------------------------------------------
  // Backing store. It has no reset, because its contents must survive
  // aresetn.
  // -------------------------------------------------------------------------
  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_ELS];

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  w_state_t                    w_state;
  w_state_t                    w_state_nx;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]            w_idx;
  logic [7:0]                  w_len;
  logic [7:0]                  w_cnt;
  logic                        w_fixed;
  logic                        w_err;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic w_last_beat;
  logic w_beat_err;
  logic mem_we;

  assign s_axi_awready = aresetn && (w_state == W_IDLE);
  assign s_axi_wready  = aresetn && (w_state == W_DATA);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;

  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = (s_axi_wlast != w_last_beat);

  // The error flag latched before this beat gates the write. A wlast
  // mismatch on this beat only affects later beats and the response.
  assign mem_we = w_hs && !w_err;

  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nx = W_RESP;
      W_RESP:  if (b_hs) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state      <= W_IDLE;
      w_id         <= '0;
      w_idx        <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_fixed      <= 1'b0;
      w_err        <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bid    <= '0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      w_state <= w_state_nx;

      if (aw_hs) begin
        w_id    <= s_axi_awid;
        w_idx   <= s_axi_awaddr[3 +: IDX_W];
        w_len   <= s_axi_awlen;
        w_cnt   <= '0;
        w_fixed <= (s_axi_awburst == 2'b00);
        w_err   <= bad_xfer(s_axi_awsize, s_axi_awburst);
      end

      if (w_hs) begin
        if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
        w_cnt <= w_cnt + 8'd1;
        if (w_beat_err) w_err <= 1'b1;
        // The response is built on the last beat so B can be valid in
        // the cycle right after it.
        if (w_last_beat) begin
          s_axi_bvalid <= 1'b1;
          s_axi_bid    <= w_id;
          s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end

      if (b_hs) s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  r_state_t         r_state;
  r_state_t         r_state_nx;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic             r_fixed;
  logic             r_err;

  logic ar_hs;
  logic r_hs;
  logic r_last_beat;

  assign s_axi_arready = aresetn && (r_state == R_IDLE);

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign r_last_beat = (r_cnt == r_len);

  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_FETCH;
      R_FETCH: r_state_nx = R_DATA;
      R_DATA:  if (r_hs) r_state_nx = r_last_beat ? R_IDLE : R_FETCH;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= R_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_fixed      <= 1'b0;
      r_err        <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rid    <= '0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rlast  <= 1'b0;
    end else begin
      r_state <= r_state_nx;

      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        r_idx     <= s_axi_araddr[3 +: IDX_W];
        r_len     <= s_axi_arlen;
        r_cnt     <= '0;
        r_fixed   <= (s_axi_arburst == 2'b00);
        r_err     <= bad_xfer(s_axi_arsize, s_axi_arburst);
      end

      // The array read is registered straight into rdata. A write to the
      // same word in this cycle lands after the read, so the old contents
      // are returned.
      if (r_state == R_FETCH) begin
        s_axi_rdata  <= r_err ? '0 : mem[r_idx];
        s_axi_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rlast  <= r_last_beat;
        s_axi_rvalid <= 1'b1;
      end

      if (r_hs) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
        if (!r_last_beat) begin
          if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;

  // The sideband fields and the non-index address bits are intentionally
  // ignored. They are folded into one signal so they stay visibly consumed.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_wid, s_axi_awaddr, s_axi_araddr};

endmodule

// File: tb/tb_zynq_axi4_mem_responder.sv
module tb_zynq_axi4_mem_responder;

  localparam int MEM_ELS = 1024;
  localparam int ID_W    = 6;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------
  logic [31:0]     s_axi_awaddr = '0;
  logic [ID_W-1:0] s_axi_awid = '0;
  logic [7:0]      s_axi_awlen = '0;
  logic [2:0]      s_axi_awsize = 3'd3;
  logic [1:0]      s_axi_awburst = 2'b01;
  logic            s_axi_awlock = 1'b0;
  logic [3:0]      s_axi_awcache = 4'h3;
  logic [2:0]      s_axi_awprot = 3'h0;
  logic [3:0]      s_axi_awqos = 4'h0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [ID_W-1:0] s_axi_wid = '0;
  logic [63:0]     s_axi_wdata = '0;
  logic [7:0]      s_axi_wstrb = '0;
  logic            s_axi_wlast = 1'b0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [ID_W-1:0] s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic [31:0]     s_axi_araddr = '0;
  logic [ID_W-1:0] s_axi_arid = '0;
  logic [7:0]      s_axi_arlen = '0;
  logic [2:0]      s_axi_arsize = 3'd3;
  logic [1:0]      s_axi_arburst = 2'b01;
  logic            s_axi_arlock = 1'b0;
  logic [3:0]      s_axi_arcache = 4'h3;
  logic [2:0]      s_axi_arprot = 3'h0;
  logic [3:0]      s_axi_arqos = 4'h0;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [63:0]     s_axi_rdata;
  logic [ID_W-1:0] s_axi_rid;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic [1:0]      dbg_w_state;
  logic [1:0]      dbg_r_state;

  zynq_axi4_mem_responder #(
    .C_S_AXI_DATA_WIDTH(64),
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_ID_WIDTH(ID_W),
    .MEM_ELS(MEM_ELS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // ---------------------------------------------------------------------
  // Reference model: a plain word array updated byte by byte, in beat order
  // ---------------------------------------------------------------------
  logic [63:0] model_mem [MEM_ELS];
  logic [63:0] wr_data [256];
  logic [7:0]  wr_strb [256];
  int total = 0;
  int bad = 0;

  function automatic int beat_word(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'(addr >> 3);
    return (base + ((burst == 2'b01) ? beat : 0)) % MEM_ELS;
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks (drive and sample on the falling edge)
  // ---------------------------------------------------------------------
  task automatic do_write(input logic [31:0] addr, input logic [ID_W-1:0] id, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int early, input int bhold);
    int n;
    logic exp_err;
    logic [1:0] exp_resp;
    int w;
    exp_err  = (size != 3'd3) || (burst > 2'd1) || (early >= 0);
    exp_resp = exp_err ? 2'b10 : 2'b00;
    @(negedge aclk);
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL aw_timeout: awready stayed %b, expected 1", s_axi_awready); end
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    total++;
    if (s_axi_wready !== 1'b1) begin bad++; $display("FAIL wready_after_aw: got %b expected 1", s_axi_wready); end
    for (int b = 0; b <= len; b++) begin
      s_axi_wdata = wr_data[b]; s_axi_wstrb = wr_strb[b];
      s_axi_wlast = (b == len) || (b == early);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
      @(negedge aclk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b1) begin bad++; $display("FAIL bvalid_latency: got %b expected 1", s_axi_bvalid); end
    for (int h = 0; h < bhold; h++) begin
      total++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_bid !== id) begin
        bad++;
        $display("FAIL b_hold: got valid=%b resp=%b id=%h expected valid=1 resp=%b id=%h",
                 s_axi_bvalid, s_axi_bresp, s_axi_bid, exp_resp, id);
      end
      @(negedge aclk);
    end
    total++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_bid !== id) begin
      bad++;
      $display("FAIL b_resp: got valid=%b resp=%b id=%h expected valid=1 resp=%b id=%h",
               s_axi_bvalid, s_axi_bresp, s_axi_bid, exp_resp, id);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b0) begin bad++; $display("FAIL b_clear: got bvalid=%b expected 0", s_axi_bvalid); end
    if (!exp_err) begin
      for (int b = 0; b <= len; b++) begin
        w = beat_word(addr, burst, b);
        for (int k = 0; k < 8; k++)
          if (wr_strb[b][k]) model_mem[w][8*k +: 8] = wr_data[b][8*k +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [ID_W-1:0] id, input int len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit rand_ready, output logic [63:0] last_data);
    int n;
    int beat;
    int iters;
    bit pending;
    bit go;
    logic exp_err;
    logic [1:0] exp_resp;
    logic [63:0] exp_data;
    exp_err  = (size != 3'd3) || (burst > 2'd1);
    exp_resp = exp_err ? 2'b10 : 2'b00;
    last_data = '0;
    @(negedge aclk);
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL ar_timeout: arready stayed %b, expected 1", s_axi_arready); end
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
    total++;
    if (s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL r_early: got rvalid=%b expected 0", s_axi_rvalid); end
    @(negedge aclk);
    total++;
    if (s_axi_rvalid !== 1'b1) begin bad++; $display("FAIL r_latency: got rvalid=%b expected 1", s_axi_rvalid); end
    beat = 0; iters = 0; pending = 1'b0;
    while (beat <= len && iters < 4000) begin
      if (s_axi_rvalid) begin
        exp_data = exp_err ? 64'h0 : model_mem[beat_word(addr, burst, beat)];
        total++;
        if (s_axi_rdata !== exp_data || s_axi_rid !== id || s_axi_rresp !== exp_resp ||
            s_axi_rlast !== (beat == len)) begin
          bad++;
          $display("FAIL r_beat%0d: got data=%h id=%h resp=%b last=%b expected data=%h id=%h resp=%b last=%b",
                   beat, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
                   exp_data, id, exp_resp, (beat == len));
        end
        last_data = s_axi_rdata;
        go = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axi_rready = go;
        pending = !go;
        if (go) beat++;
      end else begin
        if (pending) begin
          total++; bad++;
          $display("FAIL r_dropped: rvalid fell to 0 before handshake, expected 1");
          pending = 1'b0;
        end
        s_axi_rready = 1'b0;
      end
      @(negedge aclk);
      iters++;
    end
    s_axi_rready = 1'b0;
    total++;
    if (beat <= len) begin bad++; $display("FAIL r_timeout: got %0d beats expected %0d", beat, len + 1); end
    if (!rand_ready) begin
      total++;
      if (iters != 2 * len + 1) begin bad++; $display("FAIL r_throughput: got %0d cycles expected %0d", iters, 2 * len + 1); end
    end
    total++;
    if (s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL r_done: got rvalid=%b expected 0", s_axi_rvalid); end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      total++;
      if (s_axi_awready !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_wready !== 1'b0 ||
          s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 ||
          s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_bid !== '0 ||
          s_axi_rid !== '0 || s_axi_rdata !== 64'h0) begin
        bad++;
        $display("FAIL reset_outputs: got aw=%b ar=%b w=%b b=%b r=%b rl=%b bid=%h rid=%h rdata=%h expected all 0",
                 s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
                 s_axi_rlast, s_axi_bid, s_axi_rid, s_axi_rdata);
      end
    end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got awready=%b arready=%b expected 1 1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_fill();
    logic [63:0] d;
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 256; b++) begin
        wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF;
      end
      do_write(32'(blk * 2048), 6'($urandom_range(0, 63)), 255, 3'd3, 2'b01, -1, 0);
    end
    do_read(32'h0000_0800, 6'h07, 255, 3'd3, 2'b01, 1'b0, d);
  endtask

  task automatic test_incr();
    logic [63:0] d;
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = 64'h1111_1111_1111_1111 * 64'(b + 1); wr_strb[b] = 8'hFF;
    end
    do_write(32'h0000_0100, 6'h2A, 3, 3'd3, 2'b01, -1, 0);
    do_read(32'h0000_0100, 6'h15, 3, 3'd3, 2'b01, 1'b0, d);
    total++;
    if (d !== 64'h4444_4444_4444_4444) begin bad++; $display("FAIL incr_last_word: got %h expected 4444444444444444", d); end
  endtask

  task automatic test_strobes();
    logic [63:0] d;
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[0] = 8'hFF;
    do_write(32'h0000_0C80, 6'h01, 0, 3'd3, 2'b01, -1, 0);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h01;
    do_write(32'h0000_0C80, 6'h02, 0, 3'd3, 2'b01, -1, 0);
    do_read(32'h0000_0C80, 6'h03, 0, 3'd3, 2'b01, 1'b0, d);
    total++;
    if (d !== 64'hFFFF_FFFF_FFFF_FF00) begin bad++; $display("FAIL strobe_merge: got %h expected ffffffffffffff00", d); end
  endtask

  task automatic test_errors();
    logic [63:0] d;
    for (int b = 0; b < 2; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    do_write(32'h0000_0960, 6'h11, 1, 3'd2, 2'b01, -1, 0);
    do_write(32'h0000_0960, 6'h12, 1, 3'd3, 2'b10, -1, 0);
    do_read(32'h0000_0960, 6'h13, 1, 3'd3, 2'b01, 1'b0, d);
    do_read(32'h0000_0960, 6'h14, 2, 3'd2, 2'b01, 1'b0, d);
    do_read(32'h0000_0960, 6'h16, 1, 3'd3, 2'b10, 1'b1, d);
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    for (int b = 0; b < 8; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'($urandom); end
    do_write(32'h0000_0400, 6'h21, 7, 3'd3, 2'b01, -1, 10);
    do_read(32'h0000_0400, 6'h22, 7, 3'd3, 2'b01, 1'b1, d);
    // concurrent bursts to disjoint words
    for (int b = 0; b < 8; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    fork
      do_write(32'h0000_0320, 6'h23, 7, 3'd3, 2'b01, -1, 2);
      do_read(32'h0000_0FA0, 6'h24, 7, 3'd3, 2'b01, 1'b1, d);
    join
    do_read(32'h0000_0320, 6'h25, 7, 3'd3, 2'b01, 1'b0, d);
  endtask

  task automatic test_wrap();
    logic [63:0] d;
    for (int b = 0; b < 4; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    do_write(32'((MEM_ELS - 2) * 8), 6'h31, 3, 3'd3, 2'b01, -1, 0);
    do_read(32'h0000_0000, 6'h32, 1, 3'd3, 2'b01, 1'b0, d);
    total++;
    if (d !== wr_data[3]) begin bad++; $display("FAIL wrap_word1: got %h expected %h", d, wr_data[3]); end
    do_read(32'((MEM_ELS - 2) * 8), 6'h33, 3, 3'd3, 2'b01, 1'b1, d);
    // early wlast: data equals current contents so memory stays as modelled
    for (int b = 0; b < 4; b++) begin wr_data[b] = model_mem[10 + b]; wr_strb[b] = 8'hFF; end
    do_write(32'h0000_0050, 6'h34, 3, 3'd3, 2'b01, 1, 0);
    do_read(32'h0000_0050, 6'h35, 3, 3'd3, 2'b01, 1'b0, d);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    @(negedge aclk);
    s_axi_awaddr = 32'h0000_0640; s_axi_awid = 6'h3C; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_axi_wdata = model_mem[200 + b]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
      @(negedge aclk);
    end
    s_axi_wvalid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    total++;
    if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_hold: got wready=%b bvalid=%b awready=%b expected 0 0 0",
               s_axi_wready, s_axi_bvalid, s_axi_awready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_release: got awready=%b wready=%b bvalid=%b expected 1 0 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid);
    end
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [31:0] addr;
    logic [1:0] burst;
    int len;
    for (int it = 0; it < 10; it++) begin
      addr  = 32'($urandom_range(0, MEM_ELS - 1) * 8) | 32'($urandom_range(0, 7));
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 1));
      for (int b = 0; b <= len; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'($urandom); end
      do_write(addr, 6'($urandom_range(0, 63)), len, 3'd3, burst, -1, $urandom_range(0, 3));
      do_read(addr, 6'($urandom_range(0, 63)), len, 3'd3, burst, 1'b1, d);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr();
    test_strobes();
    test_errors();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
